// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle of the buffered UART transmitter: write strobe, queue status
// and the serial line itself.
interface uart_tx_fifo_if #(
  parameter int fifo_depth = 16
);
  localparam int cnt_w = $clog2(fifo_depth) + 1;

  logic [7:0]       wr_data;
  logic             wr_en;
  logic             full;
  logic             overflow;
  logic [cnt_w-1:0] fifo_cnt;
  logic             tx_busy;
  logic             data_tx;

  modport master (
    output wr_data, wr_en,
    input  full, overflow, fifo_cnt, tx_busy, data_tx
  );

  modport slave (
    input  wr_data, wr_en,
    output full, overflow, fifo_cnt, tx_busy, data_tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes are queued in a power-of-two FIFO and shifted out
// LSB first as back-to-back 8N1 (or 8E1) frames on a registered serial line.
module uart_tx_fifo #(
  parameter int baud_cnt   = 868,
  parameter int fifo_depth = 16,
  parameter bit parity_en  = 1'b0
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  uart_tx_fifo_if.slave tx_if
);
  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam int tim_w = $clog2(baud_cnt);
  localparam logic [tim_w-1:0] tim_last = tim_w'(baud_cnt - 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(fifo_depth);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] cnt;
  logic [cnt_w-1:0] cnt_nxt;
  logic             full_q;
  logic             overflow_q;
  state_t           state;
  logic [tim_w-1:0] btim;
  logic [2:0]       bidx;
  logic [7:0]       sh;
  logic             data_tx_q;
  logic             tx_busy_q;
  logic             line_bit;
  logic             wr_acc;
  logic             pop;
  logic             bit_end;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // full is the registered flag, so a pop in the same cycle cannot rescue a write
  assign wr_acc  = tx_if.wr_en && !full_q;
  assign bit_end = (btim == tim_last);
  assign pop     = (cnt != '0) && ((state == IDLE) || ((state == STOP) && bit_end));

  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc && !pop)
      cnt_nxt = cnt + cnt_w'(1);
    else if (!wr_acc && pop)
      cnt_nxt = cnt - cnt_w'(1);
  end

  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:   line_bit = 1'b0;
      DATA:    line_bit = sh[bidx];
      PARITY:  line_bit = even_parity(sh);
      default: line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)
        rd_ptr <= rd_ptr + ptr_w'(1);
      cnt        <= cnt_nxt;
      full_q     <= (cnt_nxt == cnt_full);
      overflow_q <= tx_if.wr_en && full_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_acc)
      mem[wr_ptr] <= tx_if.wr_data;
    if (pop)
      sh <= mem[rd_ptr];
  end

  // Line and busy flag are registered from the state, so they trail it by one clock
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      btim      <= '0;
      bidx      <= '0;
      data_tx_q <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      data_tx_q <= line_bit;
      tx_busy_q <= (state != IDLE);
      case (state)
        IDLE: begin
          btim <= '0;
          if (pop)
            state <= START;
        end
        START: begin
          if (bit_end) begin
            btim  <= '0;
            bidx  <= '0;
            state <= DATA;
          end else begin
            btim <= btim + tim_w'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            btim <= '0;
            if (bidx == 3'd7)
              state <= parity_en ? PARITY : STOP;
            else
              bidx <= bidx + 3'd1;
          end else begin
            btim <= btim + tim_w'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            btim  <= '0;
            state <= STOP;
          end else begin
            btim <= btim + tim_w'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            btim  <= '0;
            state <= pop ? START : IDLE;
          end else begin
            btim <= btim + tim_w'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_if.full     = full_q;
  assign tx_if.overflow = overflow_q;
  assign tx_if.fifo_cnt = cnt;
  assign tx_if.tx_busy  = tx_busy_q;
  assign tx_if.data_tx  = data_tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: two instances (no parity / even parity), baud_cnt=4,
// fifo_depth=4, with a mid-bit sampling receiver for multi-frame scenarios.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.fifo_depth(4)) if0 ();
  uart_tx_fifo_if #(.fifo_depth(4)) if1 ();

  uart_tx_fifo #(.baud_cnt(4), .fifo_depth(4), .parity_en(1'b0)) dut0 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .tx_if     (if0.slave)
  );

  uart_tx_fifo #(.baud_cnt(4), .fifo_depth(4), .parity_en(1'b1)) dut1 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .tx_if     (if1.slave)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver on dut0: finds the falling start edge, then samples each bit mid-cell.
  task automatic rx_byte(output logic [7:0] b, output int t_start, output bit ok);
    int waited;
    waited  = 0;
    ok      = 1'b1;
    b       = '0;
    t_start = -1;
    while (if0.data_tx !== 1'b0 && waited < 300) begin
      tick();
      waited++;
    end
    if (if0.data_tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t_start = cyc;
    tick(2);
    if (if0.data_tx !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(4);
      b[k] = if0.data_tx;
    end
    tick(4);
    if (if0.data_tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (if0.tx_busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (if0.tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout tx_busy=%b expected 0", if0.tx_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.wr_en = 1'b0; if0.wr_data = 8'h00;
    if1.wr_en = 1'b0; if1.wr_data = 8'h00;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({if0.data_tx, if0.tx_busy, if0.full, if0.overflow} !== 4'b1000 || if0.fifo_cnt !== 3'd0) begin
        failures++;
        $display("FAIL reset_dut0 cyc%0d line/busy/full/ovf=%b cnt=%0d expected 1000 cnt=0", i,
                 {if0.data_tx, if0.tx_busy, if0.full, if0.overflow}, if0.fifo_cnt);
      end
      checks++;
      if ({if1.data_tx, if1.tx_busy, if1.full, if1.overflow} !== 4'b1000 || if1.fifo_cnt !== 3'd0) begin
        failures++;
        $display("FAIL reset_dut1 cyc%0d line/busy/full/ovf=%b cnt=%0d expected 1000 cnt=0", i,
                 {if1.data_tx, if1.tx_busy, if1.full, if1.overflow}, if1.fifo_cnt);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    frame = 10'b1_01010101_0;
    if0.wr_data = 8'h55;
    if0.wr_en   = 1'b1;
    tick();
    if0.wr_en = 1'b0;
    checks++;
    if (if0.fifo_cnt !== 3'd1) begin
      failures++;
      $display("FAIL single_cnt_after_write got=%0d expected 1", if0.fifo_cnt);
    end
    tick();
    checks++;
    if (if0.data_tx !== 1'b1 || if0.tx_busy !== 1'b0 || if0.fifo_cnt !== 3'd0) begin
      failures++;
      $display("FAIL single_pop_edge line=%b busy=%b cnt=%0d expected 1 0 0",
               if0.data_tx, if0.tx_busy, if0.fifo_cnt);
    end
    tick();
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (if0.data_tx !== frame[b] || if0.tx_busy !== 1'b1) begin
          failures++;
          $display("FAIL single_bit%0d_clk%0d line=%b busy=%b expected %b 1",
                   b, c, if0.data_tx, if0.tx_busy, frame[b]);
        end
        tick();
      end
    end
    checks++;
    if (if0.tx_busy !== 1'b0 || if0.data_tx !== 1'b1) begin
      failures++;
      $display("FAIL single_end busy=%b line=%b expected 0 1", if0.tx_busy, if0.data_tx);
    end
  endtask

  task automatic test_parity();
    logic [10:0] frame;
    frame = 11'b1_1_00000111_0;
    if1.wr_data = 8'h07;
    if1.wr_en   = 1'b1;
    tick();
    if1.wr_en = 1'b0;
    tick(2);
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (if1.data_tx !== frame[b] || if1.tx_busy !== 1'b1) begin
          failures++;
          $display("FAIL parity_bit%0d_clk%0d line=%b busy=%b expected %b 1",
                   b, c, if1.data_tx, if1.tx_busy, frame[b]);
        end
        tick();
      end
    end
    checks++;
    if (if1.tx_busy !== 1'b0 || if1.data_tx !== 1'b1) begin
      failures++;
      $display("FAIL parity_end busy=%b line=%b expected 0 1", if1.tx_busy, if1.data_tx);
    end
  endtask

  // A leading 0x0F frame keeps the shifter busy so the whole burst lands in the queue.
  task automatic test_burst();
    logic [7:0] exp_b [5] = '{8'h0F, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] wr_b  [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    int exp_cnt [5] = '{1, 2, 3, 4, 4};
    logic exp_full [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_ovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int t_s [5];
    fork
      begin : rx_side
        logic [7:0] got;
        bit ok;
        for (int i = 0; i < 5; i++) begin
          rx_byte(got, t_s[i], ok);
          checks++;
          if (!ok || got !== exp_b[i]) begin
            failures++;
            $display("FAIL burst_rx%0d got=%h framing_ok=%0d expected %h", i, got, ok, exp_b[i]);
          end
        end
      end
      begin : drv_side
        if0.wr_data = 8'h0F;
        if0.wr_en   = 1'b1;
        tick();
        if0.wr_en = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
          if0.wr_data = wr_b[i];
          if0.wr_en   = 1'b1;
          tick();
          checks++;
          if (if0.fifo_cnt !== 3'(exp_cnt[i]) || if0.full !== exp_full[i] || if0.overflow !== exp_ovf[i]) begin
            failures++;
            $display("FAIL burst_wr%0d cnt=%0d full=%b ovf=%b expected %0d %b %b", i,
                     if0.fifo_cnt, if0.full, if0.overflow, exp_cnt[i], exp_full[i], exp_ovf[i]);
          end
        end
        if0.wr_en = 1'b0;
        tick();
        checks++;
        if (if0.overflow !== 1'b0 || if0.fifo_cnt !== 3'd4 || if0.full !== 1'b1) begin
          failures++;
          $display("FAIL burst_ovf_pulse ovf=%b cnt=%0d full=%b expected 0 4 1",
                   if0.overflow, if0.fifo_cnt, if0.full);
        end
      end
    join
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (t_s[i] - t_s[i-1] !== 40) begin
        failures++;
        $display("FAIL burst_gap%0d start_spacing=%0d expected 40", i, t_s[i] - t_s[i-1]);
      end
    end
    wait_idle0();
    checks++;
    if (if0.fifo_cnt !== 3'd0 || if0.full !== 1'b0) begin
      failures++;
      $display("FAIL burst_drained cnt=%0d full=%b expected 0 0", if0.fifo_cnt, if0.full);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    if0.wr_data = 8'h3C; if0.wr_en = 1'b1;
    tick();
    if0.wr_data = 8'h11;
    tick();
    if0.wr_data = 8'h22;
    tick();
    if0.wr_en = 1'b0;
    checks++;
    if (if0.fifo_cnt !== 3'd2 || if0.data_tx !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_setup cnt=%0d line=%b expected 2 0", if0.fifo_cnt, if0.data_tx);
    end
    tick(17);
    checks++;
    if (if0.data_tx !== 1'b1 || if0.tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_bit3 line=%b busy=%b expected 1 1", if0.data_tx, if0.tx_busy);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (if0.data_tx !== 1'b1 || if0.tx_busy !== 1'b0 || if0.fifo_cnt !== 3'd0 || if0.full !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after_reset line=%b busy=%b cnt=%0d full=%b expected 1 0 0 0",
               if0.data_tx, if0.tx_busy, if0.fifo_cnt, if0.full);
    end
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (if0.data_tx !== 1'b1 || if0.tx_busy !== 1'b0 || if0.fifo_cnt !== 3'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rstmid_quiet activity after release, line=%b busy=%b cnt=%0d expected 1 0 0",
               if0.data_tx, if0.tx_busy, if0.fifo_cnt);
    end
  endtask

  task automatic test_stop_pop();
    logic [7:0] exp_b [3] = '{8'h96, 8'h4B, 8'hE7};
    int t_s [3];
    fork
      begin : rx_side
        logic [7:0] got;
        bit ok;
        for (int i = 0; i < 3; i++) begin
          rx_byte(got, t_s[i], ok);
          checks++;
          if (!ok || got !== exp_b[i]) begin
            failures++;
            $display("FAIL stoppop_rx%0d got=%h framing_ok=%0d expected %h", i, got, ok, exp_b[i]);
          end
        end
      end
      begin : drv_side
        if0.wr_data = 8'h96; if0.wr_en = 1'b1;
        tick();
        if0.wr_data = 8'h4B;
        tick();
        if0.wr_en = 1'b0;
        checks++;
        if (if0.fifo_cnt !== 3'd1) begin
          failures++;
          $display("FAIL stoppop_queued cnt=%0d expected 1", if0.fifo_cnt);
        end
        tick(39);
        if0.wr_data = 8'hE7; if0.wr_en = 1'b1;
        checks++;
        if (if0.fifo_cnt !== 3'd1) begin
          failures++;
          $display("FAIL stoppop_before cnt=%0d expected 1", if0.fifo_cnt);
        end
        tick();
        if0.wr_en = 1'b0;
        checks++;
        if (if0.fifo_cnt !== 3'd1 || if0.tx_busy !== 1'b1) begin
          failures++;
          $display("FAIL stoppop_same_cycle cnt=%0d busy=%b expected 1 1", if0.fifo_cnt, if0.tx_busy);
        end
      end
    join
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (t_s[i] - t_s[i-1] !== 40) begin
        failures++;
        $display("FAIL stoppop_gap%0d start_spacing=%0d expected 40", i, t_s[i] - t_s[i-1]);
      end
    end
    wait_idle0();
    checks++;
    if (if0.fifo_cnt !== 3'd0) begin
      failures++;
      $display("FAIL stoppop_drained cnt=%0d expected 0", if0.fifo_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_burst();
    test_reset_mid();
    test_stop_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
